// File: rtl/alu_issue_stage.sv
// Issue stage for the combinational ALU: it assembles opcode/A/B from a byte stream, holds the
// ALU inputs for EXEC_CYCLES cycles, then returns the captured result over valid/ready.
module alu_issue_stage #(
  parameter int DATA_W      = 8,
  parameter int EXEC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] alu_opcode,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  input  logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] res_data,
  output logic              res_div0,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              illegal,
  output logic [CNT_W-1:0]  instr_cnt
);

  typedef enum logic [2:0] {
    S_OPC,
    S_OPA,
    S_OPB,
    S_EXEC,
    S_RESP
  } state_t;

  localparam logic [3:0]        EXEC_LAST = 4'(EXEC_CYCLES - 1);
  localparam logic [DATA_W-1:0] BUS_REL   = DATA_W'(8'h20);
  localparam logic [DATA_W-1:0] BIT5_CLR  = DATA_W'(8'hDF);

  state_t            state, next_state;
  logic [DATA_W-1:0] opcode;
  logic [3:0]        exec_cnt;
  logic              is_unary;
  logic              is_divmod;

  assign is_unary  = (opcode[3:0] == 4'b0100);
  assign is_divmod = (opcode[3:0] == 4'b1001) || (opcode[3:0] == 4'b1010);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_OPC;
    else        state <= next_state;
  end

  // The ALU only sees a real opcode while executing; otherwise it is parked in bus release.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    alu_opcode = BUS_REL;
    case (state)
      S_OPC: begin
        in_ready = 1'b1;
        if (in_valid && !in_data[5]) next_state = S_OPA;
      end
      S_OPA: begin
        in_ready = 1'b1;
        if (in_valid) next_state = is_unary ? S_EXEC : S_OPB;
      end
      S_OPB: begin
        in_ready = 1'b1;
        if (in_valid) next_state = S_EXEC;
      end
      S_EXEC: begin
        alu_opcode = opcode & BIT5_CLR;
        if (exec_cnt == 4'd0) next_state = S_RESP;
      end
      S_RESP: begin
        if (res_ready) next_state = S_OPC;
      end
      default: next_state = S_OPC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode    <= '0;
      alu_in1   <= '0;
      alu_in2   <= '0;
      exec_cnt  <= '0;
      res_data  <= '0;
      res_div0  <= 1'b0;
      res_valid <= 1'b0;
      illegal   <= 1'b0;
      instr_cnt <= '0;
    end else begin
      illegal <= 1'b0;
      case (state)
        S_OPC: begin
          if (in_valid) begin
            if (in_data[5]) illegal <= 1'b1;
            else            opcode  <= in_data;
          end
        end
        S_OPA: begin
          if (in_valid) begin
            alu_in1  <= in_data;
            exec_cnt <= EXEC_LAST;
            if (is_unary) alu_in2 <= '0;
          end
        end
        S_OPB: begin
          if (in_valid) begin
            alu_in2  <= in_data;
            exec_cnt <= EXEC_LAST;
          end
        end
        S_EXEC: begin
          if (exec_cnt == 4'd0) begin
            res_data  <= alu_result;
            res_div0  <= is_divmod && (alu_in2 == '0);
            res_valid <= 1'b1;
          end else begin
            exec_cnt <= exec_cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            instr_cnt <= instr_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
